// File: rtl/spi_clk_nss_gen.sv
// spi_clk_nss_gen
//   Timing front-end for the SPI shift core. Divides clk_i down to sclk_o,
//   emits one-cycle pos/neg edge strobes aligned with the new sclk level,
//   drives the core start level st_o and sequences the active-low chip
//   selects through SETUP -> RUN -> HOLD around each transfer.
//
//   Optional: define SPI_NSS_GAP_EN to add gap_i and a GAP state after HOLD
//   that keeps busy_o high (nss released) for a minimum inter-transfer gap.
//
// Ports
//   clk_i, rst_i      system clock, async active-high reset
//   en_i              block enable; low aborts back to IDLE
//   div_i             sclk half-period minus one (clk cycles)
//   cpol_i            sclk idle level
//   nss_sel_i         one-hot chip-select target
//   setup_i, hold_i   nss-to-sclk and sclk-to-nss delays (0 behaves as 1)
//   gap_i             (SPI_NSS_GAP_EN) post-transfer gap (0 behaves as 1)
//   start_i           single-cycle transfer request
//   last_i            core's final bit in flight
//   st_o              core start level, high during RUN
//   pos_edge_o        sclk rose this cycle
//   neg_edge_o        sclk fell this cycle
//   sclk_o            SPI clock
//   nss_o             active-low chip selects
//   busy_o            transfer in progress
//   done_o            one-cycle completion strobe
module spi_clk_nss_gen #(
    parameter int DIV_WIDTH = 16,
    parameter int NSS_NUM   = 4,
    parameter int DLY_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 cpol_i,
    input  logic [NSS_NUM-1:0]   nss_sel_i,
    input  logic [DLY_WIDTH-1:0] setup_i,
    input  logic [DLY_WIDTH-1:0] hold_i,
`ifdef SPI_NSS_GAP_EN
    input  logic [DLY_WIDTH-1:0] gap_i,
`endif
    input  logic                 start_i,
    input  logic                 last_i,
    output logic                 st_o,
    output logic                 pos_edge_o,
    output logic                 neg_edge_o,
    output logic                 sclk_o,
    output logic [NSS_NUM-1:0]   nss_o,
    output logic                 busy_o,
    output logic                 done_o
);

`ifdef SPI_NSS_GAP_EN
    typedef enum logic [2:0] {IDLE, SETUP, RUN, HOLD, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;
`endif

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [DLY_WIDTH:0]   DLY_ONE = (DLY_WIDTH+1)'(1);

    state_t                 state, state_d;

    // transfer configuration, captured at start
    logic [DIV_WIDTH-1:0]   div_q;
    logic                   cpol_q;
    logic [NSS_NUM-1:0]     nss_sel_q;
    logic [DLY_WIDTH-1:0]   setup_q;
    logic [DLY_WIDTH-1:0]   hold_q;
`ifdef SPI_NSS_GAP_EN
    logic [DLY_WIDTH-1:0]   gap_q;
`endif

    logic [DIV_WIDTH-1:0]   div_cnt, div_cnt_d;
    logic [DLY_WIDTH-1:0]   dly_cnt, dly_cnt_d;
    logic [DLY_WIDTH-1:0]   dly_lim;
    logic [DLY_WIDTH:0]     dly_nxt;
    logic                   dly_end;
    logic                   div_hit;
    logic                   load;

    logic                   st_d, pos_d, neg_d, sclk_d, busy_d, done_d;
    logic [NSS_NUM-1:0]     nss_d;

    assign load    = (state == IDLE) && start_i && en_i;
    assign div_hit = (div_cnt == div_q);

    // Delay phases last max(lim,1) cycles: the phase ends on the cycle where
    // the post-increment count reaches the limit (a limit of 0 ends at once).
    always_comb begin
        dly_lim = setup_q;
        case (state)
            HOLD:    dly_lim = hold_q;
`ifdef SPI_NSS_GAP_EN
            GAP:     dly_lim = gap_q;
`endif
            default: dly_lim = setup_q;
        endcase
    end

    assign dly_nxt = {1'b0, dly_cnt} + DLY_ONE;
    assign dly_end = (dly_nxt >= {1'b0, dly_lim});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q     <= '0;
            cpol_q    <= 1'b0;
            nss_sel_q <= '0;
            setup_q   <= '0;
            hold_q    <= '0;
`ifdef SPI_NSS_GAP_EN
            gap_q     <= '0;
`endif
        end else if (load) begin
            div_q     <= div_i;
            cpol_q    <= cpol_i;
            nss_sel_q <= nss_sel_i;
            setup_q   <= setup_i;
            hold_q    <= hold_i;
`ifdef SPI_NSS_GAP_EN
            gap_q     <= gap_i;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            div_cnt    <= '0;
            dly_cnt    <= '0;
            st_o       <= 1'b0;
            pos_edge_o <= 1'b0;
            neg_edge_o <= 1'b0;
            sclk_o     <= 1'b0;
            nss_o      <= '1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= state_d;
            div_cnt    <= div_cnt_d;
            dly_cnt    <= dly_cnt_d;
            st_o       <= st_d;
            pos_edge_o <= pos_d;
            neg_edge_o <= neg_d;
            sclk_o     <= sclk_d;
            nss_o      <= nss_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        div_cnt_d = div_cnt;
        dly_cnt_d = dly_cnt;
        st_d      = st_o;
        pos_d     = 1'b0;
        neg_d     = 1'b0;
        sclk_d    = sclk_o;
        nss_d     = nss_o;
        busy_d    = busy_o;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                sclk_d    = cpol_i;
                div_cnt_d = '0;
                dly_cnt_d = '0;
                if (start_i && en_i) begin
                    state_d = SETUP;
                    nss_d   = ~nss_sel_i;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (dly_end) begin
                    state_d   = RUN;
                    dly_cnt_d = '0;
                    div_cnt_d = '0;
                    st_d      = 1'b1;
                end else begin
                    dly_cnt_d = dly_nxt[DLY_WIDTH-1:0];
                end
            end
            RUN: begin
                if (div_hit) begin
                    div_cnt_d = '0;
                    // Stop only where sclk would leave idle: the last bit's
                    // trailing edge has already happened, sclk sits at cpol.
                    if ((sclk_o == cpol_q) && last_i) begin
                        state_d = HOLD;
                        st_d    = 1'b0;
                    end else begin
                        sclk_d = ~sclk_o;
                        pos_d  = ~sclk_o;
                        neg_d  = sclk_o;
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_ONE;
                end
            end
            HOLD: begin
                if (dly_end) begin
                    dly_cnt_d = '0;
                    nss_d     = '1;
`ifdef SPI_NSS_GAP_EN
                    state_d   = GAP;
`else
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
`endif
                end else begin
                    dly_cnt_d = dly_nxt[DLY_WIDTH-1:0];
                end
            end
`ifdef SPI_NSS_GAP_EN
            GAP: begin
                if (dly_end) begin
                    dly_cnt_d = '0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    dly_cnt_d = dly_nxt[DLY_WIDTH-1:0];
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Enable low wins over everything: silent abort, no done strobe.
        if (!en_i) begin
            state_d   = IDLE;
            div_cnt_d = '0;
            dly_cnt_d = '0;
            st_d      = 1'b0;
            pos_d     = 1'b0;
            neg_d     = 1'b0;
            sclk_d    = cpol_q;
            nss_d     = '1;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

endmodule
